lane_occupancy_counter: RTL

LANE_OCCUPANCY_COUNTER -- requirements
Module: lane_occupancy_counter

---
 rtl/lane_occupancy_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/lane_occupancy_counter.sv
// Per-lane saturating occupancy counters driven by entry/exit sensors,
// with edge or level event detection and sticky overflow/underflow flags.
module lane_occupancy_counter #(
    parameter int LANES     = 4,
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = 255,
    parameter int EDGE_MODE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES-1:0]       up,
    input  logic [LANES-1:0]       down,
    input  logic [LANES-1:0]       clear,
    input  logic                   err_clr,
    output logic [LANES*CNT_W-1:0] count_flat,
    output logic [LANES-1:0]       has_item,
    output logic [LANES-1:0]       full,
    output logic                   any_item,
    output logic [LANES-1:0]       err_ovf,
    output logic [LANES-1:0]       err_unf
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count     [LANES];
    logic [CNT_W-1:0] count_nxt [LANES];
    logic [LANES-1:0] up_q;
    logic [LANES-1:0] down_q;
    logic [LANES-1:0] inc;
    logic [LANES-1:0] dec;
    logic [LANES-1:0] ovf_set;
    logic [LANES-1:0] unf_set;

    always_comb begin
        if (EDGE_MODE != 0) begin
            inc = up & ~up_q;
            dec = down & ~down_q;
        end else begin
            inc = up;
            dec = down;
        end
    end

    // Simultaneous inc and dec cancel: no change and no error, even at the limits.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            count_nxt[i] = count[i];
            ovf_set[i]   = 1'b0;
            unf_set[i]   = 1'b0;
            if (clear[i]) begin
                count_nxt[i] = '0;
            end else if (inc[i] && !dec[i]) begin
                if (count[i] == MAX_C) ovf_set[i] = 1'b1;
                else                   count_nxt[i] = count[i] + CNT_W'(1);
            end else if (dec[i] && !inc[i]) begin
                if (count[i] == '0) unf_set[i] = 1'b1;
                else                count_nxt[i] = count[i] - CNT_W'(1);
            end
        end
    end

    // Sensor history loads 1 in reset so a level held across release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_q    <= '1;
            down_q  <= '1;
            err_ovf <= '0;
            err_unf <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                count[i] <= '0;
            end
        end else begin
            up_q    <= up;
            down_q  <= down;
            err_ovf <= (err_clr ? '0 : err_ovf) | ovf_set;
            err_unf <= (err_clr ? '0 : err_unf) | unf_set;
            for (int unsigned i = 0; i < LANES; i++) begin
                count[i] <= count_nxt[i];
            end
        end
    end

    always_comb begin
        count_flat = '0;
        has_item   = '0;
        full       = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            count_flat[i*CNT_W +: CNT_W] = count[i];
            has_item[i]                  = (count[i] != '0);
            full[i]                      = (count[i] == MAX_C);
        end
        any_item = |has_item;
    end

endmodule
